// File: rtl/aes_result_monitor.sv
// Watches AES self-check flags after a start pulse; reports pass, timeout and failing lanes.
// Latency: busy one edge after start; pass no earlier than STABLE_CYCLES edges after first all-ok sample.
// Backpressure: none; start is ignored while a run is busy, results hold in DONE until the next start.
module aes_result_monitor #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  encryptionCorrect,
    input  logic [3:0]  decryptionCorrect,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  fail_mask,
    output logic [15:0] cycle_count,
    output logic [7:0]  run_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETTLE, S_DONE} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  STABLE_TGT   = 4'(STABLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  stable_q, stable_d;
    logic [15:0] cycle_q, cycle_d;
    logic [7:0]  runs_q, runs_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  mask_q, mask_d;

    logic        ok;
    logic [3:0]  stable_inc;
    logic [15:0] cycle_inc;

    assign ok         = (encryptionCorrect == 4'b1111) && (decryptionCorrect == 4'b1111);
    assign stable_inc = stable_q + 4'd1;
    assign cycle_inc  = (cycle_q == 16'hFFFF) ? cycle_q : cycle_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            stable_q  <= 4'd0;
            cycle_q   <= 16'd0;
            runs_q    <= 8'd0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            mask_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            cycle_q   <= cycle_d;
            runs_q    <= runs_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        cycle_d   = cycle_q;
        runs_d    = runs_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        mask_d    = mask_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    stable_d  = 4'd0;
                    cycle_d   = 16'd0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    mask_d    = 8'd0;
                end
            end
            S_WAIT, S_SETTLE: begin
                cycle_d = cycle_inc;
                // Completion is checked before timeout so a pass on the final edge wins.
                if (ok && (stable_inc == STABLE_TGT)) begin
                    state_d   = S_DONE;
                    stable_d  = stable_inc;
                    pass_d    = 1'b1;
                    timeout_d = 1'b0;
                    mask_d    = 8'd0;
                    runs_d    = runs_q + 8'd1;
                end else if (cycle_q == TIMEOUT_LAST) begin
                    state_d   = S_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                    mask_d    = ~{decryptionCorrect, encryptionCorrect};
                    runs_d    = runs_q + 8'd1;
                end else if (ok) begin
                    state_d  = S_SETTLE;
                    stable_d = stable_inc;
                end else begin
                    state_d  = S_WAIT;
                    stable_d = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q == S_WAIT) || (state_q == S_SETTLE);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_mask   = mask_q;
    assign cycle_count = cycle_q;
    assign run_count   = runs_q;

endmodule

// File: tb/tb_aes_result_monitor.sv
// Randomized and directed bench for aes_result_monitor against a sample-sequence reference model.
module tb_aes_result_monitor;

    localparam int TO = 50;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  enc;
    logic [3:0]  dec;
    logic        busy, done, pass, timeout;
    logic [7:0]  fail_mask;
    logic [15:0] cycle_count;
    logic [7:0]  run_count;

    aes_result_monitor #(
        .TIMEOUT_CYCLES(TO),
        .STABLE_CYCLES (ST)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .encryptionCorrect(enc),
        .decryptionCorrect(dec),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .timeout          (timeout),
        .fail_mask        (fail_mask),
        .cycle_count      (cycle_count),
        .run_count        (run_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_runs = 0;
    logic [7:0]  smp [1:TO];
    logic [35:0] obs, expv;

    assign obs = {busy, done, pass, timeout, fail_mask, cycle_count, run_count};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] pk(input logic b, input logic d, input logic p, input logic t,
                                       input logic [7:0] m, input int cc);
        return {b, d, p, t, m, 16'(cc), 8'(exp_runs)};
    endfunction

    // Reference: scan the per-edge samples ({dec,enc}) for the first run of ST all-ones values;
    // if none completes by sample TO, the run times out with the inverted last sample as mask.
    function automatic void ref_model(output int last, output logic p, output logic [7:0] m);
        int run = 0;
        last = TO;
        p    = 1'b0;
        m    = 8'd0;
        for (int i = 1; i <= TO; i++) begin
            run = (smp[i] == 8'hFF) ? run + 1 : 0;
            if (run >= ST) begin
                last = i;
                p    = 1'b1;
                return;
            end
        end
        m = ~smp[TO];
    endfunction

    function automatic logic [7:0] bad_flags();
        logic [7:0] v;
        v = 8'($urandom) & ~(8'd1 << $urandom_range(0, 7));
        return v;
    endfunction

    task automatic run_and_check(input string name, input bit noisy);
        int         last;
        logic       p;
        logic [7:0] m;
        ref_model(last, p, m);
        start = 1'b1;
        step();
        start = 1'b0;
        expv = pk(1, 0, 0, 0, 8'd0, 0);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s start: got %h expected %h", name, obs, expv);
        end
        for (int i = 1; i <= last; i++) begin
            {dec, enc} = smp[i];
            start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
            step();
            if (i == last) begin
                exp_runs++;
                expv = pk(0, 1, p, !p, m, i);
            end else begin
                expv = pk(1, 0, 0, 0, 8'd0, i);
            end
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL %s edge %0d: got %h expected %h", name, i, obs, expv);
            end
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            {dec, enc} = 8'($urandom);
            step();
            n_vec++;
            if (obs !== expv) begin
                n_err++;
                $display("FAIL %s hold %0d: got %h expected %h", name, k, obs, expv);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        enc   = 4'h0;
        dec   = 4'h0;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (obs !== 36'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs, 36'h0);
        end
        start = 1'b1;
        step();
        n_vec++;
        if (obs !== 36'h0) begin
            n_err++;
            $display("FAIL start_in_reset: got %h expected %h", obs, 36'h0);
        end
        start = 1'b0;
        reset = 1'b1;
        step();
        n_vec++;
        if (obs !== 36'h0) begin
            n_err++;
            $display("FAIL idle_after_release: got %h expected %h", obs, 36'h0);
        end
    endtask

    task automatic test_all_ok();
        for (int i = 1; i <= TO; i++) smp[i] = 8'hFF;
        run_and_check("all_ok", 1'b0);
    endtask

    task automatic test_late_ok();
        for (int i = 1; i <= TO; i++) smp[i] = (i <= 20) ? 8'h00 : 8'hFF;
        run_and_check("late_ok", 1'b0);
        smp[22] = 8'hF7;
        run_and_check("settle_glitch", 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= TO; i++) smp[i] = 8'hBF;
        run_and_check("timeout_const", 1'b0);
        for (int i = 1; i <= TO; i++) smp[i] = bad_flags();
        run_and_check("timeout_rand", 1'b0);
    endtask

    task automatic test_timeout_edge();
        for (int i = 1; i <= TO; i++) smp[i] = (i <= TO - ST) ? 8'h00 : 8'hFF;
        run_and_check("pass_on_timeout_edge", 1'b0);
        for (int i = 1; i <= TO; i++) smp[i] = (i <= TO - ST + 1) ? 8'h00 : 8'hFF;
        run_and_check("short_of_pass_timeout", 1'b0);
    endtask

    task automatic test_random();
        int pct;
        for (int r = 0; r < 30; r++) begin
            pct = (r % 4 == 0) ? 40 : (r % 4 == 1) ? 75 : (r % 4 == 2) ? 90 : 97;
            for (int i = 1; i <= TO; i++)
                smp[i] = ($urandom_range(0, 99) < pct) ? 8'hFF : bad_flags();
            run_and_check("random", 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= TO; i++) smp[i] = 8'hFF;
        start = 1'b1;
        step();
        start = 1'b0;
        {dec, enc} = 8'hFF;
        step();
        step();
        #1 reset = 1'b0;
        exp_runs = 0;
        #1;
        n_vec++;
        if (obs !== 36'h0) begin
            n_err++;
            $display("FAIL reset_mid_settle: got %h expected %h", obs, 36'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        n_vec++;
        if (obs !== 36'h0) begin
            n_err++;
            $display("FAIL idle_after_mid_reset: got %h expected %h", obs, 36'h0);
        end
        run_and_check("restart_after_reset", 1'b0);
    endtask

    task automatic test_run_wrap();
        for (int i = 1; i <= TO; i++) smp[i] = 8'hFF;
        for (int r = 0; r < 255; r++) run_and_check("wrap", 1'b0);
        n_vec++;
        if (run_count !== 8'd0) begin
            n_err++;
            $display("FAIL run_count_wrap: got %0d expected 0", run_count);
        end
    endtask

    initial begin
        test_reset();
        test_all_ok();
        test_late_ok();
        test_timeout();
        test_timeout_edge();
        test_random();
        test_reset_mid();
        test_run_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
